// File: rtl/send_n_bytes.sv
// UART transmit framer: serialises a BYTE_NUM-byte word MSB-byte first as 11-bit frames
// (start, 8 data LSB first, parity, stop). Define SEND_N_BYTES_GAP_EN for a one-bit idle gap between bytes.
module send_n_bytes #(
  parameter int CLK_FREQ  = 50,
  parameter int BAUD_RATE = 9600,
  parameter int CHECK_SEL = 1,
  parameter int BYTE_NUM  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  tx_start_i,
  input  logic [8*BYTE_NUM-1:0] nbytes_data_i,
  output logic                  uart_txd_o,
  output logic                  tx_busy_o,
  output logic                  tx_nbytes_done_o
);

  localparam int BIT_CNT = CLK_FREQ * 1_000_000 / BAUD_RATE;
  localparam int CNT_W   = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
  localparam int DW      = 8 * BYTE_NUM;
  localparam logic [CNT_W-1:0] BAUD_END  = CNT_W'(BIT_CNT - 1);
  localparam logic [CNT_W-1:0] BAUD_ONE  = CNT_W'(1);
  localparam logic [3:0]       LAST_BYTE = 4'(BYTE_NUM - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
`ifdef SEND_N_BYTES_GAP_EN
    , ST_GAP
`endif
  } state_e;

  function automatic logic parity_bit(input logic [7:0] b);
    return (CHECK_SEL != 0) ? ~^b : ^b;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [3:0]       byte_idx_q, byte_idx_d;
  logic [DW-1:0]    shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             baud_end, accept, last_byte, next_byte;
  logic [7:0]       cur_byte_d;

  assign baud_end  = (baud_q == BAUD_END);
  assign accept    = (state_q == ST_IDLE) && tx_start_i;
  assign last_byte = (byte_idx_q == LAST_BYTE);
  // Only STOP (or GAP) can re-enter START, so this marks the move to the next byte.
  assign next_byte = (state_d == ST_START) && (state_q != ST_START) && (state_q != ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (tx_start_i) state_d = ST_START;
      ST_START:  if (baud_end) state_d = ST_DATA;
      ST_DATA:   if (baud_end && bit_idx_q == 3'd7) state_d = ST_PARITY;
      ST_PARITY: if (baud_end) state_d = ST_STOP;
      ST_STOP: begin
        if (baud_end) begin
          if (last_byte) state_d = ST_IDLE;
`ifdef SEND_N_BYTES_GAP_EN
          else           state_d = ST_GAP;
`else
          else           state_d = ST_START;
`endif
        end
      end
`ifdef SEND_N_BYTES_GAP_EN
      ST_GAP:    if (baud_end) state_d = ST_START;
`endif
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    baud_d     = (state_q == ST_IDLE || baud_end) ? '0 : baud_q + BAUD_ONE;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    shift_d    = shift_q;
    if (accept) begin
      bit_idx_d  = 3'd0;
      byte_idx_d = 4'd0;
      shift_d    = nbytes_data_i;
    end else begin
      // bit index wraps 7 -> 0 on its own, ready for the next byte
      if (state_q == ST_DATA && baud_end) bit_idx_d = bit_idx_q + 3'd1;
      if (state_q == ST_STOP && baud_end && !last_byte) byte_idx_d = byte_idx_q + 4'd1;
      if (next_byte) shift_d = shift_q << 8;
    end
  end

  // Line level is computed from the next state so the output flop lines up with the state flop.
  always_comb begin
    cur_byte_d = shift_d[DW-1 -: 8];
    txd_d      = 1'b1;
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = cur_byte_d[bit_idx_d];
      ST_PARITY: txd_d = parity_bit(cur_byte_d);
      default:   txd_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_STOP) && baud_end && last_byte;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      baud_q     <= '0;
      bit_idx_q  <= 3'd0;
      byte_idx_q <= 4'd0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Payload register carries data only; it is reloaded on every acceptance.
  always_ff @(posedge clk_i) begin
    shift_q <= shift_d;
  end

  assign uart_txd_o       = txd_q;
  assign tx_busy_o        = busy_q;
  assign tx_nbytes_done_o = done_q;

endmodule

// File: tb/tb_send_n_bytes.sv
// Scoreboard bench for send_n_bytes: a frame-level model pushes expected frames and done
// times; a line decoder pops and compares them.
module tb_send_n_bytes;

  localparam int CLK_FREQ  = 1;
  localparam int BAUD_RATE = 100000;
  localparam int CHECK_SEL = 1;
  localparam int B         = CLK_FREQ * 1000000 / BAUD_RATE;
`ifdef SEND_N_BYTES_GAP_EN
  localparam int BYTE_NUM  = 2;
  localparam int FRAME_P   = 12 * B;
  localparam int TOTAL     = (12 * BYTE_NUM - 1) * B;
`else
  localparam int BYTE_NUM  = 4;
  localparam int FRAME_P   = 11 * B;
  localparam int TOTAL     = BYTE_NUM * 11 * B;
`endif
  localparam int W = 8 * BYTE_NUM;

  logic clk = 1'b0;
  logic rst_i, tx_start_i;
  logic [W-1:0] data_i;
  logic uart_txd_o, tx_busy_o, tx_nbytes_done_o;

  always #5 clk = ~clk;

  send_n_bytes #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .CHECK_SEL(CHECK_SEL), .BYTE_NUM(BYTE_NUM)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .tx_start_i(tx_start_i), .nbytes_data_i(data_i),
    .uart_txd_o(uart_txd_o), .tx_busy_o(tx_busy_o), .tx_nbytes_done_o(tx_nbytes_done_o)
  );

  typedef struct { int start; logic [10:0] bits; } frame_t;
  frame_t exp_frames[$];
  int     exp_done[$];

  int cyc = 0;
  int busy_end = -1000;
  int acc_t = -1000;
  bit abort_req = 0;
  bit chk_on = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", nm, cyc, act, req);
    end
  endtask

  task automatic fail_event(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at cycle %0d", nm, cyc);
  endtask

  // Frame as a line pattern, bit 0 first: start, data LSB first, parity, stop.
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    int   ones;
    logic par;
    ones = $countones(b);
    if (CHECK_SEL != 0) par = ((ones % 2) == 0);
    else                par = ((ones % 2) == 1);
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic model_step(input logic s, input logic [W-1:0] d, input logic r);
    frame_t f;
    if (r) begin
      exp_frames.delete();
      exp_done.delete();
      busy_end  = cyc;
      acc_t     = cyc;
      abort_req = 1;
    end else if (s && cyc > busy_end) begin
      acc_t = cyc;
      for (int j = 0; j < BYTE_NUM; j++) begin
        f.start = cyc + 1 + j * FRAME_P;
        f.bits  = frame_bits(d[W-1-8*j -: 8]);
        exp_frames.push_back(f);
      end
      exp_done.push_back(cyc + 1 + TOTAL);
      busy_end = cyc + TOTAL;
    end
  endtask

  task automatic drive(input logic s, input logic [W-1:0] d, input logic r);
    @(negedge clk);
    tx_start_i = s;
    data_i     = d;
    rst_i      = r;
    model_step(s, d, r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, data_i, 1'b0);
  endtask

  task automatic wait_done();
    int n;
    n = busy_end - cyc + 3;
    if (n < 1) n = 1;
    idle(n);
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] d;
    for (int j = 0; j < BYTE_NUM; j++) d[8*j +: 8] = 8'($urandom_range(0, 255));
    return d;
  endfunction

  // Monitor: samples outputs 1 time unit after the active edge.
  bit          dec_act = 0;
  int          dec_start = 0;
  logic [10:0] dec_bits = '0;
  logic        prev_l = 1'b1;

  always @(posedge clk) begin
    int     off, bi, ph;
    frame_t f;
    #1;
    if (abort_req) begin
      abort_req = 0;
      dec_act   = 0;
      prev_l    = 1'b1;
      chk_on    = 1;
      chk("reset_line", uart_txd_o, 1);
      chk("reset_busy", tx_busy_o, 0);
      chk("reset_done", tx_nbytes_done_o, 0);
    end else if (chk_on) begin
      chk("busy", tx_busy_o, (cyc > acc_t && cyc <= busy_end) ? 1 : 0);
      if (tx_nbytes_done_o === 1'b1) begin
        if (exp_done.size() == 0) fail_event("spurious_done");
        else begin
          chk("done_cycle", cyc, exp_done.pop_front());
          chk("done_busy", tx_busy_o, 0);
          chk("done_line", uart_txd_o, 1);
        end
      end else if (exp_done.size() > 0 && cyc >= exp_done[0]) begin
        void'(exp_done.pop_front());
        fail_event("missed_done");
      end
      if (!dec_act) begin
        if (prev_l === 1'b1 && uart_txd_o === 1'b0) begin
          dec_act     = 1;
          dec_start   = cyc;
          dec_bits    = '0;
        end
      end else begin
        off = cyc - dec_start;
        bi  = off / B;
        ph  = off % B;
        if (ph == 0) dec_bits[bi] = uart_txd_o;
        else         chk("bit_hold", uart_txd_o, dec_bits[bi]);
        if (off == 11 * B - 1) begin
          dec_act = 0;
          if (exp_frames.size() == 0) fail_event("spurious_frame");
          else begin
            f = exp_frames.pop_front();
            chk("frame_start", dec_start, f.start);
            chk("frame_bits", dec_bits, f.bits);
          end
        end
      end
      if (!dec_act && exp_frames.size() > 0 && exp_frames[0].start < cyc) begin
        void'(exp_frames.pop_front());
        fail_event("missed_frame");
      end
      prev_l = uart_txd_o;
    end
  end

  initial begin
    rst_i      = 1'b1;
    tx_start_i = 1'b0;
    data_i     = '0;
    repeat (3) drive(1'b0, '0, 1'b1);
    idle(3);

    // basic transfer with a start request ignored while busy
    drive(1'b1, W'(32'hA53C_0FF0), 1'b0);
    idle(49);
    drive(1'b1, '1, 1'b0);
    drive(1'b0, '1, 1'b0);
    wait_done();

    // parity corner bytes
    drive(1'b1, W'(32'h0700_FF80), 1'b0);
    wait_done();
    idle(4);

    // reset mid-frame, then a fresh transfer
    drive(1'b1, W'(32'h5AC3_1E96), 1'b0);
    idle(124);
    drive(1'b0, data_i, 1'b1);
    idle(5);
    drive(1'b1, W'(32'h1234_5678), 1'b0);
    wait_done();

    // back-to-back with start held high
    for (int i = 0; i < 3 * (TOTAL + 1) + 2; i++) drive(1'b1, W'(32'h0102_0304), 1'b0);
    drive(1'b0, data_i, 1'b0);
    wait_done();

    // reset together with start drops the request
    drive(1'b1, W'(32'hDEAD_BEEF), 1'b1);
    idle(30);

    // random traffic with random requests and data changes while busy
    for (int t = 0; t < 10; t++) begin
      idle($urandom_range(0, 20));
      drive(1'b1, rand_word(), 1'b0);
      while (cyc <= busy_end) drive(($urandom_range(0, 3) == 0), rand_word(), 1'b0);
    end
    drive(1'b0, data_i, 1'b0);
    wait_done();
    idle(5);

    while (exp_frames.size() > 0) begin
      void'(exp_frames.pop_front());
      fail_event("frame_never_seen");
    end
    while (exp_done.size() > 0) begin
      void'(exp_done.pop_front());
      fail_event("done_never_seen");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
